// File: rtl/ubamr_pkg.sv
// ubamr_pkg: shared definitions for the UBA maintenance-register bank.
//   CR_BIT      - bus bit index of the change-register bit (bit 35, the LSB
//                 of a [0:35] backplane word)
//   HOLD_CNT_W  - width of the per-channel hold counter
//   chan_state_t- per-channel hold state (IDLE, HOLD)
//   field_base  - LSB position of channel n inside the packed field vector
//   field_top   - bus index of the field's most significant bit
package ubamr_pkg;

  localparam int unsigned CR_BIT     = 35;
  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } chan_state_t;

  function automatic int unsigned field_base(input int unsigned ch,
                                             input int unsigned width);
    return ch * width;
  endfunction

  function automatic int unsigned field_top(input int unsigned width);
    return CR_BIT + 1 - width;
  endfunction

endpackage

// File: rtl/ubamr_chan.sv
// ubamr_chan: one maintenance channel -- field register, CR hold counter
// and hold state.
//   clk, rst - clock, synchronous active-high reset
//   wr       - write strobe already decoded for this channel
//   wdata    - field value to load; wdata[0] is the CR bit
//   field    - stored field
//   strobe   - change-register strobe, high for CRHOLD cycles after a CR write
module ubamr_chan
  import ubamr_pkg::*;
#(
  parameter int MAINTW = 4,
  parameter int CRHOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [MAINTW-1:0] wdata,
  output logic [MAINTW-1:0] field,
  output logic              strobe
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(CRHOLD);

  chan_state_t           state;
  logic [HOLD_CNT_W-1:0] count;

  // A write takes priority over the terminal-count self-clear, so a CR=1
  // write on the last hold cycle restarts without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      field  <= '0;
      count  <= '0;
      state  <= IDLE;
      strobe <= 1'b0;
    end else if (wr) begin
      field <= wdata;
      if (wdata[0]) begin
        state  <= HOLD;
        count  <= HOLD_LOAD;
        strobe <= 1'b1;
      end else begin
        state  <= IDLE;
        count  <= '0;
        strobe <= 1'b0;
      end
    end else if (state == HOLD) begin
      if (count == HOLD_CNT_W'(1)) begin
        state    <= IDLE;
        count    <= '0;
        strobe   <= 1'b0;
        field[0] <= 1'b0;
      end else begin
        count <= count - HOLD_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ubamr_bank.sv
// ubamr_bank: bank of NUMCH maintenance channels on a 36-bit [0:35] bus.
//   clk, rst    - clock, synchronous active-high reset
//   busDATAI    - bus data in; field taken from [36-MAINTW:35], CR = bit 35
//   maintWRITE  - write strobe (wins over a simultaneous read)
//   maintREAD   - read strobe
//   chSEL       - channel select; values >= NUMCH are ignored but acknowledged
//   maintDATAO  - registered read data, CR always reads 0
//   maintACK    - one-cycle acknowledge after any access
//   regUBAMR    - all stored fields, channel n at [n*MAINTW +: MAINTW]
//   crSTROBE    - per-channel change-register strobes
//   crBUSY      - OR of crSTROBE
module ubamr_bank
  import ubamr_pkg::*;
#(
  parameter  int NUMCH  = 4,
  parameter  int MAINTW = 4,
  parameter  int CRHOLD = 8,
  localparam int CHW    = (NUMCH > 1) ? $clog2(NUMCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [0:35]             busDATAI,
  input  logic                    maintWRITE,
  input  logic                    maintREAD,
  input  logic [CHW-1:0]          chSEL,
  output logic [0:35]             maintDATAO,
  output logic                    maintACK,
  output logic [NUMCH*MAINTW-1:0] regUBAMR,
  output logic [NUMCH-1:0]        crSTROBE,
  output logic                    crBUSY
);

  localparam int unsigned   FLD_HI  = field_top(MAINTW);
  localparam logic [CHW:0]  NUMCH_V = (CHW+1)'(NUMCH);

  logic              sel_ok;
  logic [MAINTW-1:0] wr_field;
  logic [MAINTW-1:0] rd_field;
  logic [0:35]       rd_word;
  logic [MAINTW-1:0] chan_field [NUMCH];
  logic              unused_bus;

  assign sel_ok     = {1'b0, chSEL} < NUMCH_V;
  assign wr_field   = busDATAI[FLD_HI:CR_BIT];
  assign unused_bus = ^busDATAI[0:FLD_HI-1];
  assign crBUSY     = |crSTROBE;

  for (genvar i = 0; i < NUMCH; i++) begin : g_chan
    ubamr_chan #(
      .MAINTW (MAINTW),
      .CRHOLD (CRHOLD)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .wr     (maintWRITE && sel_ok && (chSEL == CHW'(i))),
      .wdata  (wr_field),
      .field  (chan_field[i]),
      .strobe (crSTROBE[i])
    );
    assign regUBAMR[field_base(i, MAINTW) +: MAINTW] = chan_field[i];
  end

  // CR sits in the field LSB and is masked on readback.
  always_comb begin
    rd_field = '0;
    for (int unsigned k = 0; k < NUMCH; k++) begin
      if (sel_ok && (chSEL == CHW'(k))) rd_field = chan_field[k];
    end
    rd_field[0]            = 1'b0;
    rd_word                = '0;
    rd_word[FLD_HI:CR_BIT] = rd_field;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      maintACK   <= 1'b0;
      maintDATAO <= '0;
    end else begin
      maintACK <= maintWRITE | maintREAD;
      if (maintREAD && !maintWRITE) maintDATAO <= rd_word;
    end
  end

endmodule

// File: tb/tb_ubamr_bank.sv
// tb_ubamr_bank: randomized and directed checks of ubamr_bank against a
// remaining-cycles reference model; a second NUMCH=3 instance covers
// out-of-range channel selects.
module tb_ubamr_bank;

  localparam int NUMCH  = 4;
  localparam int MAINTW = 4;
  localparam int CRHOLD = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst = 1'b1;
  logic [0:35]             bus = '0;
  logic                    wr = 1'b0, rd = 1'b0;
  logic [1:0]              sel = '0;
  logic [0:35]             dout;
  logic                    ack;
  logic [NUMCH*MAINTW-1:0] regs;
  logic [NUMCH-1:0]        strobe;
  logic                    busy;

  logic [0:35] bus3 = '0;
  logic        wr3 = 1'b0, rd3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic [0:35] dout3;
  logic        ack3;
  logic [11:0] regs3;
  logic [2:0]  strobe3;
  logic        busy3;

  ubamr_bank #(.NUMCH(NUMCH), .MAINTW(MAINTW), .CRHOLD(CRHOLD)) dut (
    .clk(clk), .rst(rst), .busDATAI(bus), .maintWRITE(wr), .maintREAD(rd),
    .chSEL(sel), .maintDATAO(dout), .maintACK(ack), .regUBAMR(regs),
    .crSTROBE(strobe), .crBUSY(busy));

  ubamr_bank #(.NUMCH(3), .MAINTW(MAINTW), .CRHOLD(CRHOLD)) dut3 (
    .clk(clk), .rst(rst), .busDATAI(bus3), .maintWRITE(wr3), .maintREAD(rd3),
    .chSEL(sel3), .maintDATAO(dout3), .maintACK(ack3), .regUBAMR(regs3),
    .crSTROBE(strobe3), .crBUSY(busy3));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-channel field value and remaining strobe cycles.
  int          m_field [NUMCH];
  int          m_rem   [NUMCH];
  logic        m_ack;
  logic [35:0] m_dout;

  int str_cnt [NUMCH];
  int busy_cnt;

  task automatic clear_counts();
    for (int c = 0; c < NUMCH; c++) str_cnt[c] = 0;
    busy_cnt = 0;
  endtask

  task automatic model_edge();
    logic [35:0] bv;
    int          mask;
    bv   = bus;
    mask = (1 << MAINTW) - 1;
    if (rst) begin
      for (int c = 0; c < NUMCH; c++) begin
        m_field[c] = 0;
        m_rem[c]   = 0;
      end
      m_ack  = 1'b0;
      m_dout = '0;
    end else begin
      if (rd && !wr)
        m_dout = (int'(sel) < NUMCH) ? 36'(m_field[sel] - (m_field[sel] % 2)) : '0;
      for (int c = 0; c < NUMCH; c++) begin
        if (wr && int'(sel) == c) begin
          m_field[c] = int'(bv) & mask;
          m_rem[c]   = bv[0] ? CRHOLD : 0;
        end else if (m_rem[c] > 0) begin
          m_rem[c]--;
          if (m_rem[c] == 0) m_field[c] = m_field[c] - (m_field[c] % 2);
        end
      end
      m_ack = wr | rd;
    end
  endtask

  task automatic step();
    logic [NUMCH-1:0]        es;
    logic [NUMCH*MAINTW-1:0] er;
    @(posedge clk);
    model_edge();
    #1;
    er = '0;
    for (int c = 0; c < NUMCH; c++) begin
      es[c] = (m_rem[c] > 0);
      er    = er | ((NUMCH*MAINTW)'(m_field[c]) << (c * MAINTW));
      if (strobe[c]) str_cnt[c]++;
    end
    if (busy) busy_cnt++;
    check("strobe", 64'(strobe), 64'(es));
    check("busy", 64'(busy), 64'(|es));
    check("ack", 64'(ack), 64'(m_ack));
    check("dout", 64'(dout), 64'(m_dout));
    check("regs", 64'(regs), 64'(er));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_write(input int ch, input logic [35:0] val);
    sel = 2'(ch); bus = val; wr = 1'b1;
    step();
    wr = 1'b0; bus = '0;
  endtask

  task automatic do_read(input int ch);
    sel = 2'(ch); rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_counts();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // Reset state read back on every channel.
    for (int c = 0; c < NUMCH; c++) begin
      do_read(c);
      check("s034_ack", 64'(ack), 64'd1);
      check("s034_dout", 64'(dout), 64'd0);
    end
    idle(1);

    // CR write on ch2: 8-cycle strobe, CR masked on read, CR cleared after hold.
    clear_counts();
    do_write(2, 36'o17);
    do_read(2);
    check("s035_rd", 64'(dout), 64'o16);
    idle(10);
    check("s035_len", 64'(str_cnt[2]), 64'd8);
    check("s035_reg", 64'(regs[11:8]), 64'hE);

    // Restart at strobe cycle 5 gives 13 continuous cycles.
    clear_counts();
    do_write(1, 36'o1);
    idle(4);
    do_write(1, 36'o1);
    idle(12);
    check("s036_restart", 64'(str_cnt[1]), 64'd13);

    // Abort at strobe cycle 3.
    clear_counts();
    do_write(1, 36'o1);
    idle(2);
    do_write(1, 36'o0);
    idle(5);
    check("s036_abort", 64'(str_cnt[1]), 64'd3);

    // Overlapping holds on ch0 and ch3.
    clear_counts();
    do_write(0, 36'o3);
    idle(1);
    do_write(3, 36'o5);
    idle(12);
    check("s037_ch0", 64'(str_cnt[0]), 64'd8);
    check("s037_ch3", 64'(str_cnt[3]), 64'd8);
    check("s037_busy", 64'(busy_cnt), 64'd10);

    // Reset mid-hold, then readback after release.
    clear_counts();
    do_write(1, 36'o17);
    idle(3);
    rst = 1'b1;
    step();
    check("s038_strobe", 64'(strobe[1]), 64'd0);
    rst = 1'b0;
    do_read(1);
    check("s038_rd", 64'(dout), 64'd0);
    idle(2);

    // Write coincident with reset is ignored.
    rst = 1'b1; sel = 2'd0; bus = 36'o17; wr = 1'b1;
    step();
    rst = 1'b0; wr = 1'b0; bus = '0;
    idle(2);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      wr  = ($urandom_range(0, 4) == 0);
      rd  = ($urandom_range(0, 2) == 0);
      sel = 2'($urandom);
      bus = 36'({$urandom(), $urandom()});
      step();
    end
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    idle(CRHOLD + 2);

    // NUMCH=3 instance: channel select 3 is out of range.
    sel3 = 2'd2; bus3 = 36'o16; wr3 = 1'b1;
    step3();
    wr3 = 1'b0;
    check("s039_setup", 64'(regs3), 64'hE00);
    sel3 = 2'd3; bus3 = 36'o17; wr3 = 1'b1;
    step3();
    wr3 = 1'b0; bus3 = '0;
    check("s039_wr_ack", 64'(ack3), 64'd1);
    check("s039_wr_reg", 64'(regs3), 64'hE00);
    check("s039_wr_str", 64'(strobe3), 64'd0);
    sel3 = 2'd2; rd3 = 1'b1;
    step3();
    check("s039_rd2", 64'(dout3), 64'o16);
    sel3 = 2'd3;
    step3();
    rd3 = 1'b0;
    check("s039_rd3", 64'(dout3), 64'd0);
    check("s039_rd_ack", 64'(ack3), 64'd1);
    step3();
    check("s039_ack_drop", 64'(ack3), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ubamr_bank.md
UBAMR_BANK -- requirements
Module: ubamr_bank

Interface
REQ-001 The block SHALL have parameter NUMCH, default 4: number of maintenance channels (1..8).
REQ-002 The block SHALL have parameter MAINTW, default 4: maintenance field width, taken from busDATAI[36-MAINTW:35] (2..18).
REQ-003 The block SHALL have parameter CRHOLD, default 8: cycles the change-register strobe stays asserted (1..255).
REQ-004 The block SHALL have port clk, input, 1: clock; the block uses one clock.
REQ-005 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 The block SHALL have port busDATAI, input, 36 [0:35]: backplane bus data in.
REQ-007 The block SHALL have port maintWRITE, input, 1: single-cycle write strobe.
REQ-008 The block SHALL have port maintREAD, input, 1: single-cycle read strobe.
REQ-009 The block SHALL have port chSEL, input, clog2(NUMCH) (min 1): channel select, sampled with the strobe.
REQ-010 The block SHALL have port maintDATAO, output, 36 [0:35]: read data.
REQ-011 The block SHALL have port maintACK, output, 1: access acknowledge.
REQ-012 The block SHALL have port regUBAMR, output, NUMCH*MAINTW: stored fields, with channel n at [n*MAINTW +: MAINTW].
REQ-013 The block SHALL have port crSTROBE, output, NUMCH: per-channel change-register strobe.
REQ-014 The block SHALL have port crBUSY, output, 1: OR of all crSTROBE bits.

Function
REQ-015 On maintWRITE, the field of channel chSEL SHALL load busDATAI[36-MAINTW:35] at the next clock edge.
REQ-016 Bit 35 (CR) SHALL be the change-register bit, and the remaining field bits SHALL be plain read/write maintenance bits.
REQ-017 Each channel SHALL contain an 8-bit hold counter with two states, IDLE and HOLD.
REQ-018 A write with CR=1 SHALL move the channel from IDLE to HOLD, load the counter with CRHOLD, and assert crSTROBE[ch] from the cycle after the write.
REQ-019 In HOLD, the counter SHALL decrement each cycle, and at count 1 the channel SHALL return to IDLE, deassert crSTROBE, and clear the stored CR bit; crSTROBE is therefore high for exactly CRHOLD cycles.
REQ-020 A write with CR=1 during HOLD SHALL reload CRHOLD (restart) without a strobe gap.
REQ-021 A write with CR=0 during HOLD SHALL abort: IDLE and strobe low on the next cycle.
REQ-022 A write landing on the terminal-count cycle SHALL take priority over the self-clear.
REQ-023 On maintREAD, maintDATAO SHALL present the selected field in [36-MAINTW:35], zeros elsewhere, with CR always read as 0, registered one cycle after the strobe and held until the next read.
REQ-024 maintACK SHALL pulse high for one cycle, one cycle after any maintWRITE or maintREAD.
REQ-025 Simultaneous maintWRITE and maintREAD SHALL be treated as write-only, with maintDATAO unchanged and a single maintACK.
REQ-026 A chSEL value of NUMCH or greater SHALL ignore writes, read as 0, and still acknowledge.
REQ-027 Channels SHALL be independent, with concurrent HOLD permitted on any number of channels.

Reset
REQ-028 While rst=1 at a clock edge, all fields SHALL become 0, all counters 0, all channels IDLE, and crSTROBE, crBUSY, maintACK and maintDATAO SHALL be 0.
REQ-029 Reset asserted mid-HOLD SHALL drop crSTROBE on the next edge, with no residual pulse after release.
REQ-030 Strobes coincident with rst SHALL be ignored.

Structure
REQ-031 Package ubamr_pkg SHALL hold the CR bit index (35), the field-position helper, and the channel state encoding (IDLE, HOLD).
REQ-032 One sub-module, ubamr_chan, SHALL be instantiated NUMCH times, each containing one field register, counter and state.
REQ-033 The top level SHALL contain only decode, read mux, ACK and crBUSY.

Verification
REQ-034 Scenario: reset, then read channel 0..3 -> maintDATAO=0 each, maintACK one cycle after each read.
REQ-035 Scenario: write ch2 data 0o000000000017 (field 1111) -> crSTROBE[2] high 8 cycles starting the cycle after the write; readback 0o000000000016; regUBAMR ch2=1110 after hold.
REQ-036 Scenario: write ch1 CR=1, then rewrite CR=1 at strobe cycle 5 -> total strobe 13 cycles continuous; rewrite CR=0 at cycle 3 instead -> strobe 3 cycles.
REQ-037 Scenario: write ch0 and ch3 CR=1 two cycles apart -> independent 8-cycle strobes; crBUSY high 10 cycles.
REQ-038 Scenario: assert rst at strobe cycle 4 of ch1 -> crSTROBE[1]=0 next edge; field reads 0 after release.
REQ-039 Scenario: NUMCH=3, chSEL=3 write 0o17 -> no state change; read returns 0; ACK pulses.
